// File: rtl/kronos_copier_pkg.sv
// kronos_copier_pkg
//   Shared types and constants for the kronos_obi_copier word-copy engine:
//   register-bus and OBI bus structs, register offsets, CTRL/STATUS bit
//   positions, the FSM state enum and default widths.
//   Optional feature macro: KRONOS_COPIER_PERF_EN (busy-cycle counter at 0x14).
package kronos_copier_pkg;

    localparam int LEN_W_DEF      = 16;
    localparam int REG_ADDR_W_DEF = 5;

    // Register offsets (byte addresses of 32-bit words)
    localparam logic [31:0] OFF_SRC    = 32'h00;
    localparam logic [31:0] OFF_DST    = 32'h04;
    localparam logic [31:0] OFF_LEN    = 32'h08;
    localparam logic [31:0] OFF_CTRL   = 32'h0C;
    localparam logic [31:0] OFF_STATUS = 32'h10;
    localparam logic [31:0] OFF_PERF   = 32'h14;

    localparam int CTRL_START_BIT   = 0;
    localparam int CTRL_INTR_EN_BIT = 1;
    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_DONE_BIT  = 1;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } reg_req_t;

    typedef struct packed {
        logic        ready;
        logic        error;
        logic [31:0] rdata;
    } reg_rsp_t;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_WAIT = 3'd4
    } copier_state_e;

endpackage

// File: rtl/kronos_copier_reg_if.sv
// kronos_copier_reg_if
//   Register decode and storage for the copier: SRC, DST, LEN, CTRL, STATUS
//   and (optionally) PERF. Generates the accepted-START pulse and resolves the
//   DONE set/clear priority (set wins).
//   Optional feature macro: KRONOS_COPIER_PERF_EN. When undefined, the PERF
//   offset stays mapped and reads 0.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   reg_req       register bus request
//   reg_rsp       register bus response (always ready, combinational rdata)
//   busy          engine is not idle; blocks SRC/DST/LEN/START writes
//   done_set      engine completion (or zero-length START) this cycle
//   src, dst      word-aligned base addresses
//   len           word count
//   intr_en       interrupt enable
//   done          completion flag
//   start         accepted START pulse
module kronos_copier_reg_if
    import kronos_copier_pkg::*;
#(
    parameter int LEN_W      = LEN_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  reg_req_t         reg_req,
    output reg_rsp_t         reg_rsp,
    input  logic             busy,
    input  logic             done_set,
    output logic [31:0]      src,
    output logic [31:0]      dst,
    output logic [LEN_W-1:0] len,
    output logic             intr_en,
    output logic             done,
    output logic             start
);

    logic [REG_ADDR_W-1:0] off;
    logic hit_src, hit_dst, hit_len, hit_ctrl, hit_status, hit_perf;
    logic wr;
    logic done_clr;
    logic [31:0] perf_rd;

    assign off        = reg_req.addr[REG_ADDR_W-1:0];
    assign hit_src    = (off == REG_ADDR_W'(OFF_SRC));
    assign hit_dst    = (off == REG_ADDR_W'(OFF_DST));
    assign hit_len    = (off == REG_ADDR_W'(OFF_LEN));
    assign hit_ctrl   = (off == REG_ADDR_W'(OFF_CTRL));
    assign hit_status = (off == REG_ADDR_W'(OFF_STATUS));
    assign hit_perf   = (off == REG_ADDR_W'(OFF_PERF));
    assign wr         = reg_req.valid & reg_req.write;

    assign start    = wr & hit_ctrl & reg_req.wdata[CTRL_START_BIT] & ~busy;
    assign done_clr = start | (wr & hit_status & reg_req.wdata[STATUS_DONE_BIT]);

    // Byte strobes and the undecoded address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{reg_req.wstrb, reg_req.addr[31:REG_ADDR_W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            src     <= '0;
            dst     <= '0;
            len     <= '0;
            intr_en <= 1'b0;
            done    <= 1'b0;
        end else begin
            if (wr && hit_src && !busy) src <= {reg_req.wdata[31:2], 2'b00};
            if (wr && hit_dst && !busy) dst <= {reg_req.wdata[31:2], 2'b00};
            if (wr && hit_len && !busy) len <= reg_req.wdata[LEN_W-1:0];
            if (wr && hit_ctrl)         intr_en <= reg_req.wdata[CTRL_INTR_EN_BIT];
            // Completion in the same cycle as a clear keeps DONE set.
            if (done_set)      done <= 1'b1;
            else if (done_clr) done <= 1'b0;
        end
    end

`ifdef KRONOS_COPIER_PERF_EN
    logic [31:0] perf;
    always_ff @(posedge clk) begin
        if (rst || start)                perf <= '0;
        else if (busy && perf != '1)     perf <= perf + 32'd1;
    end
    assign perf_rd = perf;
`else
    assign perf_rd = '0;
`endif

    always_comb begin
        reg_rsp       = '0;
        reg_rsp.ready = 1'b1;
        if (hit_src)         reg_rsp.rdata = src;
        else if (hit_dst)    reg_rsp.rdata = dst;
        else if (hit_len)    reg_rsp.rdata = 32'(len);
        else if (hit_ctrl)   reg_rsp.rdata = {30'd0, intr_en, 1'b0};
        else if (hit_status) reg_rsp.rdata = {30'd0, done, busy};
        else if (hit_perf)   reg_rsp.rdata = perf_rd;
        else                 reg_rsp.error = reg_req.valid;
    end

endmodule

// File: rtl/kronos_obi_copier.sv
// kronos_obi_copier
//   Register-programmed word-copy engine acting as an OBI initiator. Software
//   programs SRC, DST and LEN, then writes START; the engine reads and writes
//   one word at a time with a single outstanding transaction and raises a
//   level interrupt on completion.
//   Optional feature macro: KRONOS_COPIER_PERF_EN (busy-cycle counter).
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   reg_req_i     register bus request
//   reg_rsp_o     register bus response
//   obi_req_o     OBI request (req, we, be, addr, wdata)
//   obi_resp_i    OBI response (gnt, rvalid, rdata)
//   done_intr_o   completion interrupt (DONE & INTR_EN, registered)
//
// Handshake: an OBI request is held with every field stable from the cycle
// req rises until the cycle gnt is sampled high; req drops the next cycle.
// The response is taken on the first rvalid seen in the matching WAIT state;
// rvalid in any other state is ignored.
module kronos_obi_copier
    import kronos_copier_pkg::*;
#(
    parameter int LEN_W      = LEN_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  reg_req_t  reg_req_i,
    output reg_rsp_t  reg_rsp_o,
    output obi_req_t  obi_req_o,
    input  obi_resp_t obi_resp_i,
    output logic      done_intr_o
);

    copier_state_e    state, state_next;
    logic [LEN_W-1:0] idx;
    logic [31:0]      data_buf;
    logic [31:0]      src, dst;
    logic [LEN_W-1:0] len;
    logic             intr_en, done, start, busy, done_set, last;
    logic [31:0]      rd_addr, wr_addr;

    assign busy    = (state != ST_IDLE);
    assign last    = (idx == len - LEN_W'(1));
    // Address arithmetic wraps modulo 2^32.
    assign rd_addr = src + (32'(idx) << 2);
    assign wr_addr = dst + (32'(idx) << 2);
    assign done_set = (start && len == '0)
                    || (state == ST_WR_WAIT && obi_resp_i.rvalid && last);

    kronos_copier_reg_if #(
        .LEN_W      (LEN_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_reg_if (
        .clk      (clk_i),
        .rst      (rst_i),
        .reg_req  (reg_req_i),
        .reg_rsp  (reg_rsp_o),
        .busy     (busy),
        .done_set (done_set),
        .src      (src),
        .dst      (dst),
        .len      (len),
        .intr_en  (intr_en),
        .done     (done),
        .start    (start)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            idx         <= '0;
            data_buf    <= '0;
            done_intr_o <= 1'b0;
        end else begin
            state <= state_next;
            if (start)
                idx <= '0;
            else if (state == ST_WR_WAIT && obi_resp_i.rvalid && !last)
                idx <= idx + LEN_W'(1);
            if (state == ST_RD_WAIT && obi_resp_i.rvalid)
                data_buf <= obi_resp_i.rdata;
            done_intr_o <= done & intr_en;
        end
    end

    always_comb begin
        state_next = state;
        obi_req_o  = '0;
        case (state)
            ST_IDLE: begin
                if (start && len != '0) state_next = ST_RD_REQ;
            end
            ST_RD_REQ: begin
                obi_req_o.req  = 1'b1;
                obi_req_o.be   = 4'hF;
                obi_req_o.addr = rd_addr;
                if (obi_resp_i.gnt) state_next = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (obi_resp_i.rvalid) state_next = ST_WR_REQ;
            end
            ST_WR_REQ: begin
                obi_req_o.req   = 1'b1;
                obi_req_o.we    = 1'b1;
                obi_req_o.be    = 4'hF;
                obi_req_o.addr  = wr_addr;
                obi_req_o.wdata = data_buf;
                if (obi_resp_i.gnt) state_next = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (obi_resp_i.rvalid) state_next = last ? ST_IDLE : ST_RD_REQ;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule
